fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//   Program-flow controller for the core's program counter. Owns PC and a run/stall/halt FSM.
//   Starts a program on a start pulse and advances PC by +1 or by a taken-branch offset.
//   Holds PC for multi-cycle data-memory ops and reports done on HALT.
//   Sits between the decoder (op, z/lt flags, branch offset) and instruction ROM (PC, instr_valid).
// PARAMETERS
//   PC_W      8      PC / instruction address width
//   OP_W      5      opcode width; matches the definitions package
//   BAMT_W    15     branch-offset width, two's complement
//   MEM_LAT   2      cycles PC is held for LD/ST; legal range >= 1
//   WDOG_MAX  4096   watchdog limit in cycles; used only with FETCH_WATCHDOG_EN
// PORTS
//   clk          in   1        clock; all state updates on posedge
//   reset        in   1        synchronous, active-high reset
//   start        in   1        one-cycle pulse: begin execution at start_addr
//   start_addr   in   PC_W     program entry address
//   op           in   OP_W     decoded opcode of instruction at PC
//   z            in   1        ALU zero flag
//   lt           in   1        ALU less-than flag
//   bamt         in   BAMT_W   signed branch offset, relative to current PC
//   PC           out  PC_W     program counter, registered
//   instr_valid  out  1        1 when state==RUN (op/flags consumed this cycle)
//   done         out  1        registered; 1 in HALT
//   fault        out  1        registered; 1 if halted by watchdog; constant 0 without macro
// BEHAVIOUR
//   States: IDLE, RUN, WAIT, HALT. Reset -> IDLE; PC=0, done=0, fault=0, wait count=0.
//   IDLE:  start=1 -> PC<=start_addr, RUN. Otherwise hold.
//   RUN, checked in priority order:
//     1. op==HALT -> HALT; PC held; done=1 from next cycle.
//     2. op==LD or ST -> WAIT, cnt<=MEM_LAT-1; PC held.
//     3. taken -> PC <= PC + bamt[PC_W-1:0], mod 2^PC_W.
//        taken = BA | (BL & lt) | (BG & !lt) | (BE & z).
//     4. otherwise -> PC <= PC+1, mod 2^PC_W (PC=2^PC_W-1 wraps to 0).
//   WAIT:  cnt!=0 -> cnt--. cnt==0 -> PC<=PC+1, RUN.
//          Total LD/ST occupancy is MEM_LAT+1 cycles, counting the RUN cycle.
//   HALT:  done held at 1; PC held. start=1 -> done<=0, fault<=0, PC<=start_addr, RUN.
//   start is ignored in RUN and WAIT: no restart mid-program.
//   op, z, lt, bamt are sampled only when instr_valid=1; ignored in IDLE, WAIT and HALT.
//   reset has priority over all events, including a simultaneous start.
//   Mid-operation reset returns to IDLE with PC=0 on the next edge.
//   Branch offset 0 (BA with bamt=0) is legal: PC holds and the sequencer spins in RUN.
// CONFIGURATION
//   FETCH_WATCHDOG_EN defined:
//     - wd counter, width $clog2(WDOG_MAX+1), cleared on start; increments in RUN and WAIT.
//     - On reaching WDOG_MAX-1 with no HALT op that cycle: next edge -> HALT, fault=1, done=1.
//     - A HALT op in the same cycle takes priority: fault=0.
//   Not defined: no counter; fault tied to 0; programs may run indefinitely.
// STRUCTURE
//   definitions package: opcode constants HALT, LD, ST, BA, BL, BG, BE;
//     typedef enum logic [1:0] {IDLE, RUN, WAIT, HALT_S} fetch_state_t.
//   Single module; the branch-taken decode is an inline function, not a sub-module.
//   Optional sub-module: fetch_wdog (watchdog counter), instantiated only under FETCH_WATCHDOG_EN.
// TESTING
//   1. reset; start, start_addr=8'h10; ops NOP x3 -> PC 10,11,12,13; instr_valid=1 each cycle.
//   2. RUN at PC=20: BE, z=1, bamt=-5 -> PC=15. BE, z=0 -> PC=21.
//      BL, lt=1, bamt=3 -> PC+3. BG, lt=1 -> PC+1.
//   3. LD at PC=30, MEM_LAT=2 -> PC=30 for 3 cycles; instr_valid 1,0,0; then PC=31.
//   4. PC=8'hFF with NOP -> PC=0. PC=8'h02 with BA, bamt=-4 -> PC=8'hFE.
//   5. HALT at PC=40 -> done=1 next cycle, PC stays 40.
//      start, start_addr=0 -> done=0, PC=0.
//      reset asserted while in WAIT -> IDLE, PC=0.
//   6. With FETCH_WATCHDOG_EN, WDOG_MAX=16: BA, bamt=0 loop -> fault=1, done=1 after 16 cycles.
//      HALT op in cycle 16 instead -> fault=0.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: default sizes, opcode encodings, FSM states.
package fetch_sequencer_pkg;

  localparam int unsigned FS_PC_W      = 8;
  localparam int unsigned FS_OP_W      = 5;
  localparam int unsigned FS_BAMT_W    = 15;
  localparam int unsigned FS_MEM_LAT   = 2;
  localparam int unsigned FS_WDOG_MAX  = 4096;

  // Opcodes the sequencer reacts to; every other encoding advances PC by one.
  localparam logic [FS_OP_W-1:0] NOP  = 5'd0;
  localparam logic [FS_OP_W-1:0] HALT = 5'd1;
  localparam logic [FS_OP_W-1:0] LD   = 5'd2;
  localparam logic [FS_OP_W-1:0] ST   = 5'd3;
  localparam logic [FS_OP_W-1:0] BA   = 5'd4;
  localparam logic [FS_OP_W-1:0] BL   = 5'd5;
  localparam logic [FS_OP_W-1:0] BG   = 5'd6;
  localparam logic [FS_OP_W-1:0] BE   = 5'd7;

  typedef enum logic [1:0] {IDLE, RUN, WAIT, HALT_S} fetch_state_t;

endpackage

// File: rtl/fetch_sequencer_wdog.sv
// Watchdog cycle counter for fetch_sequencer (built only when FETCH_WATCHDOG_EN is defined).
module fetch_wdog
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned WDOG_MAX = FS_WDOG_MAX
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic active_i,
  output logic expire_c_o
);

  localparam int unsigned WD_W = $clog2(WDOG_MAX + 1);

  logic [WD_W-1:0] cnt_q;
  logic [WD_W-1:0] cnt_d;

  // Count active cycles since the last program start, saturating at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (active_i && (cnt_q != WD_W'(WDOG_MAX))) begin
      cnt_d = cnt_q + WD_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Last allowed active cycle: the sequencer halts with a fault on the next edge.
  assign expire_c_o = active_i && (cnt_q == WD_W'(WDOG_MAX - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: IDLE/RUN/WAIT/HALT control of PC for the core.
// Optional watchdog halt enabled by defining FETCH_WATCHDOG_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned PC_W     = FS_PC_W,
  parameter int unsigned OP_W     = FS_OP_W,
  parameter int unsigned BAMT_W   = FS_BAMT_W,
  parameter int unsigned MEM_LAT  = FS_MEM_LAT,
  parameter int unsigned WDOG_MAX = FS_WDOG_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic [OP_W-1:0]   op,
  input  logic              z,
  input  logic              lt,
  input  logic [BAMT_W-1:0] bamt,
  output logic [PC_W-1:0]   PC,
  output logic              instr_valid,
  output logic              done,
  output logic              fault
);

  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             fault_q, fault_d;
  logic             iv_q, iv_d;
  logic             start_ok;
  logic             wd_expire;

  // Branch condition decode for the opcode currently at PC.
  function automatic logic branch_taken(input logic [OP_W-1:0] o, input logic zf,
                                        input logic ltf);
    return (o == OP_W'(BA)) || ((o == OP_W'(BL)) && ltf) ||
           ((o == OP_W'(BG)) && !ltf) || ((o == OP_W'(BE)) && zf);
  endfunction

  // Next-state, PC and status logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    fault_d  = fault_q;
    start_ok = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          pc_d     = start_addr;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (op == OP_W'(HALT)) begin
          state_d = HALT_S;
          done_d  = 1'b1;
        end else if (wd_expire) begin
          state_d = HALT_S;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else if ((op == OP_W'(LD)) || (op == OP_W'(ST))) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end else if (branch_taken(op, z, lt)) begin
          pc_d = pc_q + bamt[PC_W-1:0];
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      WAIT: begin
        if (wd_expire) begin
          state_d = HALT_S;
          done_d  = 1'b1;
          fault_d = 1'b1;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = RUN;
        end
      end
      HALT_S: begin
        if (start) begin
          start_ok = 1'b1;
          done_d   = 1'b0;
          fault_d  = 1'b0;
          pc_d     = start_addr;
          state_d  = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // instr_valid is registered from the next state so it is high exactly while in RUN.
  assign iv_d = (state_d == RUN);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      iv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      iv_q    <= iv_d;
    end
  end

  assign PC          = pc_q;
  assign instr_valid = iv_q;
  assign done        = done_q;

`ifdef FETCH_WATCHDOG_EN
  // Watchdog counts RUN/WAIT cycles and restarts with each accepted start.
  fetch_wdog #(
    .WDOG_MAX(WDOG_MAX)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (start_ok),
    .active_i  ((state_q == RUN) || (state_q == WAIT)),
    .expire_c_o(wd_expire)
  );

  assign fault = fault_q;
`else
  // Without the watchdog a program may run indefinitely and never faults.
  logic unused_cfg;

  assign wd_expire  = 1'b0;
  assign fault      = 1'b0;
  assign unused_cfg = start_ok ^ fault_q ^ (WDOG_MAX == 0);
`endif

  // Upper offset bits are beyond the PC range and drop out of the modular add.
  logic unused_bamt;
  assign unused_bamt = ^bamt[BAMT_W-1:PC_W];

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed program steps plus random ops vs. a model.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int PC_W    = 8;
  localparam int OP_W    = 5;
  localparam int BAMT_W  = 15;
  localparam int MEM_LAT = 2;
`ifdef FETCH_WATCHDOG_EN
  localparam int WDOG_MAX = 16;
  localparam bit WD_EN    = 1'b1;
`else
  localparam int WDOG_MAX = 4096;
  localparam bit WD_EN    = 1'b0;
`endif
  localparam int PC_MASK = (1 << PC_W) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [PC_W-1:0]   start_addr = '0;
  logic [OP_W-1:0]   op = '0;
  logic              z = 1'b0;
  logic              lt = 1'b0;
  logic [BAMT_W-1:0] bamt = '0;
  logic [PC_W-1:0]   PC;
  logic              instr_valid;
  logic              done;
  logic              fault;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  int m_mode = M_IDLE;
  int m_pc   = 0;
  int m_rem  = 0;
  int m_wd   = 0;
  bit m_done = 1'b0;
  bit m_fault = 1'b0;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .PC_W(PC_W), .OP_W(OP_W), .BAMT_W(BAMT_W), .MEM_LAT(MEM_LAT), .WDOG_MAX(WDOG_MAX)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .op(op),
    .z(z), .lt(lt), .bamt(bamt), .PC(PC), .instr_valid(instr_valid), .done(done),
    .fault(fault)
  );

  // Advance the model by one clock with the currently driven inputs, then let the DUT clock.
  task automatic tick();
    bit act, hit, tk;
    if (reset) begin
      m_mode = M_IDLE; m_pc = 0; m_done = 0; m_fault = 0; m_wd = 0; m_rem = 0;
    end else begin
      act = (m_mode == M_RUN) || (m_mode == M_WAIT);
      hit = WD_EN && act && (m_wd == WDOG_MAX - 1);
      case (op)
        BA: tk = 1'b1;
        BL: tk = lt;
        BG: tk = !lt;
        BE: tk = z;
        default: tk = 1'b0;
      endcase
      case (m_mode)
        M_IDLE: if (start) begin m_pc = int'(start_addr); m_mode = M_RUN; m_wd = 0; end
        M_RUN: begin
          if (op == HALT) begin m_mode = M_HALT; m_done = 1; end
          else if (hit) begin m_mode = M_HALT; m_done = 1; m_fault = 1; end
          else if (op == LD || op == ST) begin m_mode = M_WAIT; m_rem = MEM_LAT; end
          else if (tk) m_pc = (m_pc + int'($signed(bamt))) & PC_MASK;
          else m_pc = (m_pc + 1) & PC_MASK;
        end
        M_WAIT: begin
          if (hit) begin m_mode = M_HALT; m_done = 1; m_fault = 1; end
          else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin m_pc = (m_pc + 1) & PC_MASK; m_mode = M_RUN; end
          end
        end
        default: if (start) begin
          m_pc = int'(start_addr); m_mode = M_RUN; m_done = 0; m_fault = 0; m_wd = 0;
        end
      endcase
      if (act) m_wd = m_wd + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag);
    n_assert++;
    assert (PC === PC_W'(m_pc)) else begin
      n_fail++; $error("FAIL %s PC got %0h exp %0h", tag, PC, m_pc);
    end
    n_assert++;
    assert (instr_valid === (m_mode == M_RUN)) else begin
      n_fail++; $error("FAIL %s instr_valid got %b exp %b", tag, instr_valid, m_mode == M_RUN);
    end
    n_assert++;
    assert (done === m_done) else begin
      n_fail++; $error("FAIL %s done got %b exp %b", tag, done, m_done);
    end
    n_assert++;
    assert (fault === m_fault) else begin
      n_fail++; $error("FAIL %s fault got %b exp %b", tag, fault, m_fault);
    end
  endtask

  // Hand-derived expectations for the directed points.
  task automatic expect_const(input string tag, input int pc, input bit iv, input bit dn);
    n_assert++;
    assert (PC === PC_W'(pc) && instr_valid === iv && done === dn) else begin
      n_fail++;
      $error("FAIL %s got PC=%0h iv=%b done=%b exp PC=%0h iv=%b done=%b",
             tag, PC, instr_valid, done, pc, iv, dn);
    end
  endtask

  task automatic step(input string tag, input bit st, input int addr, input logic [OP_W-1:0] o,
                      input bit zz, input bit ll, input int b);
    reset = 1'b0; start = st; start_addr = PC_W'(addr); op = o; z = zz; lt = ll;
    bamt = BAMT_W'(b);
    tick();
    check(tag);
  endtask

  task automatic do_reset(input bit with_start);
    reset = 1'b1; start = with_start; start_addr = 8'h77; op = NOP;
    tick();
    check("reset");
    expect_const("reset_c", 0, 1'b0, 1'b0);
  endtask

  initial begin
    int r;
    do_reset(1'b0);
    // 1: start and straight-line execution
    step("start", 1, 'h10, NOP, 0, 0, 0);
    expect_const("start_c", 'h10, 1'b1, 1'b0);
    step("nop1", 0, 0, NOP, 0, 0, 0);
    step("nop2", 0, 0, NOP, 0, 0, 0);
    step("nop3", 0, 0, NOP, 0, 0, 0);
    expect_const("nop3_c", 'h13, 1'b1, 1'b0);
    step("start_ignored", 1, 'h55, NOP, 0, 0, 0);
    expect_const("start_ign_c", 'h14, 1'b1, 1'b0);
    // 2: conditional branches
    do_reset(1'b0);
    step("start20", 1, 20, NOP, 0, 0, 0);
    step("be_taken", 0, 0, BE, 1, 0, -5);
    expect_const("be_taken_c", 15, 1'b1, 1'b0);
    step("be_not", 0, 0, BE, 0, 0, -5);
    expect_const("be_not_c", 16, 1'b1, 1'b0);
    step("bl_taken", 0, 0, BL, 0, 1, 3);
    expect_const("bl_taken_c", 19, 1'b1, 1'b0);
    step("bg_not", 0, 0, BG, 0, 1, 7);
    expect_const("bg_not_c", 20, 1'b1, 1'b0);
    // 3: LD holds PC for MEM_LAT+1 cycles
    do_reset(1'b0);
    step("start30", 1, 30, NOP, 0, 0, 0);
    step("ld", 0, 0, LD, 0, 0, 0);
    expect_const("ld_w1", 30, 1'b0, 1'b0);
    step("ld_w2", 0, 0, HALT, 0, 0, 0);
    expect_const("ld_w2_c", 30, 1'b0, 1'b0);
    step("ld_end", 0, 0, NOP, 0, 0, 0);
    expect_const("ld_end_c", 31, 1'b1, 1'b0);
    // 4: PC wrap in both directions
    do_reset(1'b0);
    step("startff", 1, 'hFF, NOP, 0, 0, 0);
    step("wrap_up", 0, 0, NOP, 0, 0, 0);
    expect_const("wrap_up_c", 0, 1'b1, 1'b0);
    do_reset(1'b0);
    step("start02", 1, 2, NOP, 0, 0, 0);
    step("wrap_dn", 0, 0, BA, 0, 0, -4);
    expect_const("wrap_dn_c", 'hFE, 1'b1, 1'b0);
    // 5: HALT, restart, reset in WAIT, reset beats start
    do_reset(1'b0);
    step("start40", 1, 40, NOP, 0, 0, 0);
    step("halt", 0, 0, HALT, 0, 0, 0);
    expect_const("halt_c", 40, 1'b0, 1'b1);
    step("halt_hold", 0, 0, NOP, 0, 0, 0);
    expect_const("halt_hold_c", 40, 1'b0, 1'b1);
    step("restart", 1, 0, NOP, 0, 0, 0);
    expect_const("restart_c", 0, 1'b1, 1'b0);
    step("st", 0, 0, ST, 0, 0, 0);
    do_reset(1'b0);
    do_reset(1'b1);
    // Zero-offset BA spins; with the watchdog it ends in a fault
    step("spin_start", 1, 'h33, NOP, 0, 0, 0);
    for (int i = 0; i < 16; i++) step("spin", 0, 0, BA, 0, 0, 0);
`ifdef FETCH_WATCHDOG_EN
    n_assert++;
    assert (fault === 1'b1 && done === 1'b1) else begin
      n_fail++; $error("FAIL wdog_fault got fault=%b done=%b exp 1 1", fault, done);
    end
    step("wd_restart", 1, 'h33, NOP, 0, 0, 0);
    for (int i = 0; i < 15; i++) step("spin2", 0, 0, BA, 0, 0, 0);
    step("wd_halt", 0, 0, HALT, 0, 0, 0);
    n_assert++;
    assert (fault === 1'b0 && done === 1'b1) else begin
      n_fail++; $error("FAIL wdog_halt got fault=%b done=%b exp 0 1", fault, done);
    end
`else
    expect_const("spin_c", 'h33, 1'b1, 1'b0);
`endif
    // Random programs against the model
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      start = ($urandom_range(0, 5) == 0);
      start_addr = PC_W'($urandom);
      r = $urandom_range(0, 99);
      if (r < 4) op = HALT;
      else if (r < 12) op = LD;
      else if (r < 18) op = ST;
      else if (r < 30) op = BA;
      else if (r < 42) op = BL;
      else if (r < 54) op = BG;
      else if (r < 66) op = BE;
      else if (r < 74) op = OP_W'($urandom_range(8, 31));
      else op = NOP;
      z = 1'($urandom); lt = 1'($urandom); bamt = BAMT_W'($urandom);
      tick();
      check("rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
